// File: rtl/imm_encode_loader.sv
// imm_encode_loader: range-checks an immediate, scatters it into the I/S/B
// field positions of a base instruction, and writes the packed word to
// instruction memory at consecutive word addresses.
module imm_encode_loader #(
    parameter  int                ADDR_W    = 32,
    parameter  logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter  int                DEPTH     = 64,
    localparam int                CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       base_instr,
    input  logic [31:0]       imm,
    input  logic [1:0]        ImmSrc,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              full,
    output logic              err_range,
    output logic              err_src,
    output logic [CNT_W-1:0]  words_written
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [1:0] SRC_I = 2'b00;
    localparam logic [1:0] SRC_S = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;

    logic [1:0]        r_state;
    logic [24:0]       r_base;
    logic [31:0]       r_imm;
    logic [1:0]        r_src;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err_range;
    logic              r_err_src;

    logic              w_full;
    logic              w_legal;
    logic [31:0]       w_packed;
    logic              w_unused_base;

    // Bits [31:25] of the base word are always overwritten by the immediate.
    assign w_unused_base = ^base_instr[31:25];

    assign w_full        = (r_cnt == CNT_W'(DEPTH));
    assign in_ready      = (r_state == S_IDLE) && !w_full;
    assign full          = w_full;
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign err_range     = r_err_range;
    assign err_src       = r_err_src;
    assign words_written = r_cnt;

    // Range check and field scatter for the latched request.
    always_comb begin
        w_legal  = 1'b0;
        w_packed = '0;
        case (r_src)
            SRC_I: begin
                w_legal  = (&r_imm[31:11]) || !(|r_imm[31:11]);
                w_packed = {r_imm[11:0], r_base[19:0]};
            end
            SRC_S: begin
                w_legal  = (&r_imm[31:11]) || !(|r_imm[31:11]);
                w_packed = {r_imm[11:5], r_base[24:12], r_imm[4:0], r_base[6:0]};
            end
            SRC_B: begin
                w_legal  = !r_imm[0] && ((&r_imm[31:12]) || !(|r_imm[31:12]));
                w_packed = {r_imm[12], r_imm[10:5], r_base[24:12],
                            r_imm[4:1], r_imm[11], r_base[6:0]};
            end
            default: begin
                w_legal  = 1'b0;
                w_packed = '0;
            end
        endcase
    end

    // Request FSM, memory write handshake, counters and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_imm       <= '0;
            r_src       <= '0;
            r_we        <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_err_range <= 1'b0;
            r_err_src   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_base  <= base_instr[24:0];
                        r_imm   <= imm;
                        r_src   <= ImmSrc;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_src == 2'b11) begin
                        r_err_src <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (!w_legal) begin
                        r_err_range <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wdata <= w_packed;
                        r_we    <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        r_we    <= 1'b0;
                        r_addr  <= r_addr + ADDR_W'(4);
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
